// File: rtl/mem_lsu_if.sv
// mem_lsu_if: request, store-data, load-data and memory pin bundle for mem_lsu.
// slave is the LSU side; master is the requester/memory side.
interface mem_lsu_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 3
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic              req_dec;
    logic              wd_valid;
    logic              wd_ready;
    logic [DATA_W-1:0] wd_data;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic              done;
    logic [ADDR_W-1:0] mem_adr;
    logic [DATA_W-1:0] mem_WD;
    logic              mem_WE;
    logic [DATA_W-1:0] mem_Memout;
    modport slave (
        input  req_valid, req_write, req_addr, req_len, req_dec, wd_valid, wd_data, mem_Memout,
        output req_ready, wd_ready, rd_valid, rd_data, rd_last, done, mem_adr, mem_WD, mem_WE
    );
    modport master (
        output req_valid, req_write, req_addr, req_len, req_dec, wd_valid, wd_data, mem_Memout,
        input  req_ready, wd_ready, rd_valid, rd_data, rd_last, done, mem_adr, mem_WD, mem_WE
    );
endinterface

// File: rtl/mem_lsu.sv
// mem_lsu: burst load/store initiator for a word-addressed memory, 1..8 beats per request.
// Define MEM_LSU_DEC_EN to build descending-address bursts selected by req_dec.
module mem_lsu #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 3
) (
    input logic      clk,
    input logic      rst,
    mem_lsu_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RD, WR} state_t;
    state_t            state;
    logic [ADDR_W-1:0] adr;
    logic [ADDR_W-1:0] adr_nxt;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  cnt;
    logic              last;
    logic              beat;
`ifdef MEM_LSU_DEC_EN
    logic              dec;
    assign adr_nxt = dec ? adr - ADDR_W'(1) : adr + ADDR_W'(1);
`else
    logic              unused_dec;
    assign unused_dec = bus.req_dec;
    assign adr_nxt    = adr + ADDR_W'(1);
`endif
    assign last         = cnt == len;
    assign beat         = state == RD || (state == WR && bus.wd_valid);
    assign bus.req_ready = state == IDLE && !rst;
    assign bus.wd_ready  = state == WR && !rst;
    // write enable is gated by rst so a reset landing mid-burst never commits a beat
    assign bus.mem_WE    = bus.wd_valid && bus.wd_ready;
    assign bus.mem_WD    = state == WR ? bus.wd_data : '0;
    assign bus.mem_adr   = adr;
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            adr         <= '0;
            len         <= '0;
            cnt         <= '0;
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
            bus.rd_last  <= 1'b0;
            bus.done     <= 1'b0;
`ifdef MEM_LSU_DEC_EN
            dec         <= 1'b0;
`endif
        end else begin
            bus.rd_valid <= state == RD;
            bus.rd_last  <= state == RD && last;
            bus.done     <= beat && last;
            if (state == RD) bus.rd_data <= bus.mem_Memout;
            if (state == IDLE) begin
                if (bus.req_valid) begin
                    adr   <= bus.req_addr;
                    len   <= bus.req_len;
                    cnt   <= '0;
                    state <= bus.req_write ? WR : RD;
`ifdef MEM_LSU_DEC_EN
                    dec   <= bus.req_dec;
`endif
                end
            end else if (beat) begin
                adr <= adr_nxt;
                cnt <= cnt + LEN_W'(1);
                if (last) state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed stimulus with a queue scoreboard for load beats and done pulses.
module tb_mem_lsu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic init = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   we_cnt = 0;
    logic [15:0] mem [8192];
    typedef struct {logic [15:0] d; logic l; int c;} rd_t;
    rd_t  rd_q [$];
    int   done_q [$];
    rd_t  mon_e;
    int   mon_c;

    mem_lsu_if bus ();
    mem_lsu dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < 8192; i++) mem[i] <= 16'h0;
            mem[0] <= 16'd25; mem[1] <= 16'd20; mem[2] <= 16'd30;
            mem[3] <= 16'h0033; mem[4] <= 16'h0044;
            mem[8190] <= 16'h1FFE; mem[8191] <= 16'h1FFF;
            for (int i = 0; i < 4; i++) mem[100 + i] <= 16'hA000 + 16'(i);
        end else if (bus.mem_WE) begin
            mem[bus.mem_adr] <= bus.mem_WD;
            we_cnt <= we_cnt + 1;
        end
    end
    assign bus.mem_Memout = bus.mem_WE ? 16'h0 : mem[bus.mem_adr];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (bus.rd_valid === 1'b1) begin
            chk("rd_expected", 32'(rd_q.size() != 0), 1);
            if (rd_q.size() != 0) begin
                mon_e = rd_q.pop_front();
                chk("rd_data", 32'(bus.rd_data), 32'(mon_e.d));
                chk("rd_last", 32'(bus.rd_last), 32'(mon_e.l));
                chk("rd_cycle", cyc, mon_e.c);
            end
        end
        if (bus.done === 1'b1) begin
            chk("done_expected", 32'(done_q.size() != 0), 1);
            if (done_q.size() != 0) begin
                mon_c = done_q.pop_front();
                chk("done_cycle", cyc, mon_c);
            end
        end
    end

    task automatic issue(input logic w, input logic [12:0] a, input int len, input logic dec, output int c0);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = a;
        bus.req_len = 3'(len); bus.req_dec = dec;
        chk("req_ready_idle", 32'(bus.req_ready), 1);
        @(posedge clk); #1;
        c0 = cyc;
    endtask

    task automatic load(input logic [12:0] a, input int n, input logic dec,
                        input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2, input logic [15:0] d3);
        logic [15:0] d [4];
        int c0;
        d = '{d0, d1, d2, d3};
        issue(1'b0, a, n - 1, dec, c0);
        bus.req_valid = 1'b0;
        for (int k = 0; k < n; k++) rd_q.push_back('{d[k], k == n - 1, c0 + k + 1});
        done_q.push_back(c0 + n);
        repeat (n + 2) @(posedge clk);
    endtask

    task automatic store(input logic [12:0] a, input int n, input int gap, input logic [15:0] d0, input logic [15:0] d1);
        logic [15:0] d [2];
        int c0, w0;
        d = '{d0, d1};
        issue(1'b1, a, n - 1, 1'b0, c0);
        bus.req_valid = 1'b0;
        w0 = we_cnt;
        for (int k = 0; k < n; k++) begin
            if (k > 0) repeat (gap) begin
                @(negedge clk); bus.wd_valid = 1'b0; #1;
                chk("we_stall", 32'(bus.mem_WE), 0);
            end
            @(negedge clk);
            chk("wd_ready", 32'(bus.wd_ready), 1);
            bus.wd_valid = 1'b1; bus.wd_data = d[k];
            @(posedge clk); #1;
        end
        done_q.push_back(cyc);
        @(negedge clk);
        bus.wd_valid = 1'b0;
        chk("we_pulses", we_cnt - w0, n);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int c0, c1, w0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_len = '0;
        bus.req_dec = 1'b0; bus.wd_valid = 1'b0; bus.wd_data = '0;
        @(posedge clk); #1 init = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 0);
        chk("rst_mem_WE", 32'(bus.mem_WE), 0);
        chk("rst_wd_ready", 32'(bus.wd_ready), 0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 0);
        chk("rst_rd_last", 32'(bus.rd_last), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_mem_adr", 32'(bus.mem_adr), 0);
        chk("rst_rd_data", 32'(bus.rd_data), 0);
        rst = 1'b0; #1;
        chk("post_rst_req_ready", 32'(bus.req_ready), 1);

        load(13'd0, 3, 1'b0, 16'd25, 16'd20, 16'd30, 16'h0);
        store(13'd5, 2, 2, 16'h1234, 16'h00FF);
        chk("store_mem5", 32'(mem[5]), 32'h1234);
        chk("store_mem6", 32'(mem[6]), 32'h00FF);
        load(13'd5, 2, 1'b0, 16'h1234, 16'h00FF, 16'h0, 16'h0);
        load(13'd8190, 4, 1'b0, 16'h1FFE, 16'h1FFF, 16'd25, 16'd20);
`ifdef MEM_LSU_DEC_EN
        load(13'd2, 3, 1'b1, 16'd30, 16'd20, 16'd25, 16'h0);
`else
        load(13'd2, 3, 1'b1, 16'd30, 16'h0033, 16'h0044, 16'h0);
`endif

        issue(1'b1, 13'd100, 3, 1'b0, c0);
        bus.req_valid = 1'b0;
        w0 = we_cnt;
        @(negedge clk); bus.wd_valid = 1'b1; bus.wd_data = 16'hBEEF;
        @(posedge clk); #1;
        @(negedge clk); bus.wd_data = 16'hDEAD; rst = 1'b1; #1;
        chk("rst_mid_store_WE", 32'(bus.mem_WE), 0);
        chk("rst_mid_store_wd_ready", 32'(bus.wd_ready), 0);
        @(posedge clk); #1;
        @(negedge clk); rst = 1'b0; bus.wd_valid = 1'b0; #1;
        chk("rst_mid_store_req_ready", 32'(bus.req_ready), 1);
        repeat (3) @(posedge clk); #1;
        chk("rst_mid_store_mem100", 32'(mem[100]), 32'hBEEF);
        chk("rst_mid_store_mem101", 32'(mem[101]), 32'hA001);
        chk("rst_mid_store_writes", we_cnt - w0, 1);

        issue(1'b0, 13'd0, 2, 1'b0, c0);
        for (int k = 0; k < 3; k++) rd_q.push_back('{k == 0 ? 16'd25 : (k == 1 ? 16'd20 : 16'd30), k == 2, c0 + k + 1});
        done_q.push_back(c0 + 3);
        bus.req_addr = 13'd1; bus.req_len = 3'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("req_ready_held", 32'(bus.req_ready), i == 3 ? 1 : 0);
        end
        @(posedge clk); #1;
        c1 = cyc;
        bus.req_valid = 1'b0;
        chk("held_accept_cycle", c1, c0 + 4);
        rd_q.push_back('{16'd20, 1'b1, c1 + 1});
        done_q.push_back(c1 + 1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rd_q_drained", rd_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
